// File: rtl/game_move_sequencer.sv
// Sequences 2048 moves: button edge detect and arbitration, move/spawn handshakes, win/lose, move counter.
// Latency: a press sampled in IDLE gives move_req next cycle; a sampled done drops its req next cycle.
// Backpressure: reqs hold until the engine's done pulse; presses outside IDLE are dropped (buffered one-deep with MOVE_QUEUE_EN).
module game_move_sequencer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    output logic             move_req,
    output logic [1:0]       move_dir,
    input  logic             move_done,
    input  logic             move_changed,
    output logic             spawn_req,
    output logic [3:0]       spawn_rnd,
    input  logic             spawn_done,
    input  logic             spawn_ok,
    input  logic             win_flag,
    input  logic             no_moves,
    output logic             busy,
    output logic             q_Init,
    output logic             q_Idle,
    output logic             q_Move,
    output logic             q_Spawn,
    output logic             q_Win,
    output logic             q_Lose,
    output logic [CNT_W-1:0] move_count
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_MOVE  = 3'd2,
        S_SPAWN = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    // An all-zero Fibonacci LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0]      LFSR_INIT = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;

    // Button bit order throughout: {up, down, left, right}.
    logic [3:0]        btn_lvl;
    logic [3:0]        btn_prev_q;
    logic [3:0]        btn_press;
    logic              press_vld;
    logic [1:0]        press_dir;

    logic [15:0]       lfsr_q, lfsr_d;
    logic [1:0]        dir_q, dir_d;
    logic [3:0]        rnd_q, rnd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              pend_vld_q;
    logic [1:0]        pend_dir_q;

    assign btn_lvl = {up, down, left, right};

    // Rising-edge detect: level high now, low in the previous cycle.
    always_comb begin
        btn_press = btn_lvl & ~btn_prev_q;
    end

    // Fixed-priority arbitration up > down > left > right; losers are dropped.
    always_comb begin
        press_vld = |btn_press;
        press_dir = 2'b11;
        if (btn_press[3]) begin
            press_dir = 2'b00;
        end else if (btn_press[2]) begin
            press_dir = 2'b01;
        end else if (btn_press[1]) begin
            press_dir = 2'b10;
        end
    end

    // Free-running Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // Game FSM next state, move direction, counter, spawn hint and decoded outputs.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        rnd_d     = rnd_q;
        move_req  = 1'b0;
        spawn_req = 1'b0;
        q_Init    = 1'b0;
        q_Idle    = 1'b0;
        q_Move    = 1'b0;
        q_Spawn   = 1'b0;
        q_Win     = 1'b0;
        q_Lose    = 1'b0;
        busy      = 1'b0;

        case (state_q)
            S_INIT: begin
                q_Init  = 1'b1;
                busy    = 1'b1;
                state_d = S_SPAWN;
            end
            S_SPAWN: begin
                q_Spawn   = 1'b1;
                busy      = 1'b1;
                spawn_req = 1'b1;
                if (spawn_done) begin
                    state_d = spawn_ok ? S_IDLE : S_LOSE;
                end
            end
            S_IDLE: begin
                q_Idle = 1'b1;
                // A buffered press is older than anything arriving now, so it goes first.
                if (win_flag) begin
                    state_d = S_WIN;
                end else if (no_moves) begin
                    state_d = S_LOSE;
                end else if (pend_vld_q) begin
                    state_d = S_MOVE;
                    dir_d   = pend_dir_q;
                end else if (press_vld) begin
                    state_d = S_MOVE;
                    dir_d   = press_dir;
                end
            end
            S_MOVE: begin
                q_Move   = 1'b1;
                busy     = 1'b1;
                move_req = 1'b1;
                if (move_done) begin
                    if (move_changed) begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                        state_d = S_SPAWN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WIN: begin
                q_Win = 1'b1;
            end
            S_LOSE: begin
                q_Lose = 1'b1;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        // The spawn hint is frozen for the whole SPAWN visit.
        if ((state_d == S_SPAWN) && (state_q != S_SPAWN)) begin
            rnd_d = lfsr_q[3:0];
        end
    end

`ifdef MOVE_QUEUE_EN
    logic       pend_vld_d;
    logic [1:0] pend_dir_d;

    // First press seen while the engine is busy is held; cleared when used or when the game ends.
    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_dir_d = pend_dir_q;
        if (((state_q == S_MOVE) || (state_q == S_SPAWN)) && press_vld && !pend_vld_q) begin
            pend_vld_d = 1'b1;
            pend_dir_d = press_dir;
        end
        if ((state_q == S_IDLE) && (state_d == S_MOVE)) begin
            pend_vld_d = 1'b0;
        end
        if ((state_d == S_WIN) || (state_d == S_LOSE)) begin
            pend_vld_d = 1'b0;
        end
    end

    // Pending-press buffer registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend_vld_q <= 1'b0;
            pend_dir_q <= 2'b00;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_dir_q <= pend_dir_d;
        end
    end
`else
    assign pend_vld_q = 1'b0;
    assign pend_dir_q = 2'b00;
`endif

    // State and datapath registers; prev levels reset high so a button held through reset is not a press.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_INIT;
            btn_prev_q <= 4'b1111;
            lfsr_q     <= LFSR_INIT;
            dir_q      <= 2'b00;
            rnd_q      <= LFSR_SEED[3:0];
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            btn_prev_q <= btn_lvl;
            lfsr_q     <= lfsr_d;
            dir_q      <= dir_d;
            rnd_q      <= rnd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign move_dir   = dir_q;
    assign spawn_rnd  = rnd_q;
    assign move_count = cnt_q;

endmodule

// File: tb/tb_game_move_sequencer.sv
module tb_game_move_sequencer;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          CW   = 3;
    localparam int          CMAX = 7;

    logic          Clk, Reset;
    logic          up, down, left, right;
    logic          move_req;
    logic [1:0]    move_dir;
    logic          move_done, move_changed;
    logic          spawn_req;
    logic [3:0]    spawn_rnd;
    logic          spawn_done, spawn_ok;
    logic          win_flag, no_moves;
    logic          busy;
    logic          q_Init, q_Idle, q_Move, q_Spawn, q_Win, q_Lose;
    logic [CW-1:0] move_count;

    game_move_sequencer #(.LFSR_SEED(SEED), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset),
        .up(up), .down(down), .left(left), .right(right),
        .move_req(move_req), .move_dir(move_dir),
        .move_done(move_done), .move_changed(move_changed),
        .spawn_req(spawn_req), .spawn_rnd(spawn_rnd),
        .spawn_done(spawn_done), .spawn_ok(spawn_ok),
        .win_flag(win_flag), .no_moves(no_moves),
        .busy(busy),
        .q_Init(q_Init), .q_Idle(q_Idle), .q_Move(q_Move),
        .q_Spawn(q_Spawn), .q_Win(q_Win), .q_Lose(q_Lose),
        .move_count(move_count)
    );

    typedef struct {
        bit is_spawn;
        int cyc;
        int val;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   cnt_m = 0;
    bit   pend_v = 0;
    int   pend_d = 0;
    logic mv_prev = 1'b0;
    logic sp_prev = 1'b0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Cycle index since reset release: cycle 0 is the first cycle the DUT sits in INIT.
    always @(posedge Clk) cyc <= Reset ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_exp(input bit sp, input int c, input int v, input int n);
        exp_t e;
        e.is_spawn = sp;
        e.cyc      = c;
        e.val      = v;
        e.cnt      = n;
        sb.push_back(e);
    endtask

    // Reference LFSR: x^16+x^14+x^13+x^11+1, value held during cycle n after reset.
    function automatic int lfsr_at(input int n);
        int v = SEED;
        int fb;
        for (int i = 0; i < n; i++) begin
            fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
            v  = (v >> 1) | (fb << 15);
        end
        return v;
    endfunction

    function automatic int dir_of(input logic [3:0] m);
        if (m[3]) return 0;
        if (m[2]) return 1;
        if (m[1]) return 2;
        return 3;
    endfunction

    // Monitor: every rising request is matched against the next expected event.
    task automatic check_event(input bit sp);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_%s: got request at cycle %0d, required none",
                     sp ? "spawn_req" : "move_req", cyc);
        end else begin
            e = sb.pop_front();
            chk("req_kind", {31'd0, sp}, {31'd0, e.is_spawn});
            chk("req_cycle", cyc, e.cyc);
            if (sp) begin
                chk("spawn_rnd", {28'd0, spawn_rnd}, e.val);
                chk("count_at_spawn", {29'd0, move_count}, e.cnt);
            end else begin
                chk("move_dir", {30'd0, move_dir}, e.val);
            end
        end
    endtask

    always @(negedge Clk) begin
        if (move_req === 1'b1 && mv_prev !== 1'b1) check_event(1'b0);
        if (spawn_req === 1'b1 && sp_prev !== 1'b1) check_event(1'b1);
        mv_prev <= move_req;
        sp_prev <= spawn_req;
    end

    task automatic wait_req(input bit sp);
        int n = 0;
        while (((sp ? spawn_req : move_req) !== 1'b1) && n < 40) begin
            tick();
            n++;
        end
        if ((sp ? spawn_req : move_req) !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL wait_%s: got no request in 40 cycles, required one",
                     sp ? "spawn_req" : "move_req");
        end
    endtask

    // mode: 0 terminal state, 1 IDLE (move expected), 2 engine busy (may be buffered)
    task automatic press(input logic [3:0] m, input int mode);
        {up, down, left, right} = m;
        if (mode == 1) begin
            push_exp(1'b0, cyc + 1, dir_of(m), 0);
        end else if (mode == 2) begin
`ifdef MOVE_QUEUE_EN
            if (!pend_v) begin
                pend_v = 1'b1;
                pend_d = dir_of(m);
            end
`endif
        end
        tick();
        {up, down, left, right} = 4'b0000;
    endtask

    task automatic serve_move(input int lat, input bit changed, input int hold);
        int d;
        wait_req(1'b0);
        repeat (lat) tick();
        move_done    = 1'b1;
        move_changed = changed;
        d = cyc;
        if (changed) begin
            if (cnt_m < CMAX) cnt_m++;
            push_exp(1'b1, d + 1, lfsr_at(d) & 15, cnt_m);
        end else if (pend_v) begin
            push_exp(1'b0, d + 2, pend_d, 0);
            pend_v = 1'b0;
        end
        tick();
        if (hold > 1) tick();
        move_done    = 1'b0;
        move_changed = 1'b0;
    endtask

    task automatic serve_spawn(input int lat, input bit ok, input int hold);
        int d;
        wait_req(1'b1);
        repeat (lat) tick();
        spawn_done = 1'b1;
        spawn_ok   = ok;
        d = cyc;
        if (ok && pend_v) push_exp(1'b0, d + 2, pend_d, 0);
        pend_v = 1'b0;
        tick();
        if (hold > 1) tick();
        spawn_done = 1'b0;
        spawn_ok   = 1'b0;
    endtask

    task automatic do_move(input logic [3:0] m, input int lat, input bit changed,
                           input int hold, input int slat);
        press(m, 1);
        serve_move(lat, changed, hold);
        if (changed) serve_spawn(slat, 1'b1, 1);
    endtask

    task automatic apply_reset(input int n);
        Reset = 1'b1;
        repeat (n) tick();
        Reset  = 1'b0;
        cnt_m  = 0;
        pend_v = 1'b0;
        push_exp(1'b1, 1, lfsr_at(0) & 15, 0);
    endtask

    task automatic check_reset_state();
        chk("rst_q_Init", q_Init, 1);
        chk("rst_other_states", {q_Idle, q_Move, q_Spawn, q_Win, q_Lose}, 0);
        chk("rst_busy", busy, 1);
        chk("rst_move_req", move_req, 0);
        chk("rst_spawn_req", spawn_req, 0);
        chk("rst_move_dir", move_dir, 0);
        chk("rst_spawn_rnd", spawn_rnd, SEED[3:0]);
        chk("rst_move_count", move_count, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, required finish within 300us");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        {up, down, left, right} = 4'b1000;   // up held through reset
        move_done = 0; move_changed = 0; spawn_done = 0; spawn_ok = 0;
        win_flag = 0; no_moves = 0;

        // Reset, first spawn, held button is not a press
        apply_reset(3);
        check_reset_state();
        serve_spawn(2, 1'b1, 1);
        chk("idle_after_first_spawn", q_Idle, 1);
        chk("busy_in_idle", busy, 0);
        repeat (3) tick();
        up = 1'b0;
        repeat (3) tick();

        // Simultaneous up+right: one request, up wins
        do_move(4'b1001, 2, 1'b0, 1, 0);
        chk("idle_after_unchanged", q_Idle, 1);
        repeat (3) tick();

        // Unchanged move: no spawn, count held
        do_move(4'b0010, 1, 1'b0, 1, 0);
        chk("no_spawn_after_unchanged", spawn_req, 0);
        chk("count_unchanged", move_count, 0);

        // Changed move with done held two cycles: counted once
        press(4'b0100, 1);
        serve_move(2, 1'b1, 2);
        serve_spawn(1, 1'b1, 2);
        chk("count_after_change", move_count, 1);
        chk("idle_after_spawn", q_Idle, 1);

        // Stray done pulses in IDLE are ignored
        move_done = 1; move_changed = 1; spawn_done = 1; spawn_ok = 0;
        tick();
        move_done = 0; move_changed = 0; spawn_done = 0;
        chk("stray_done_stays_idle", q_Idle, 1);
        chk("stray_done_count", move_count, cnt_m);

        // Presses during SPAWN: right first, then up
        press(4'b0100, 1);
        serve_move(1, 1'b1, 1);
        press(4'b0001, 2);
        tick();
        press(4'b1000, 2);
        serve_spawn(1, 1'b1, 1);
`ifdef MOVE_QUEUE_EN
        serve_move(1, 1'b0, 1);
`else
        repeat (4) tick();
`endif
        chk("idle_after_spawn_presses", q_Idle, 1);

        // Randomized moves
        for (int i = 0; i < 10; i++) begin
            do_move(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 2), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) tick();
        end

        // Drive counter to all-ones, then one more changing move
        for (int i = 0; i < 8 && cnt_m < CMAX; i++) do_move(4'b0010, 0, 1'b1, 1, 0);
        do_move(4'b0001, 1, 1'b1, 1, 1);
        chk("count_saturated", move_count, CMAX);

        // win_flag has priority over no_moves; WIN is terminal
        win_flag = 1; no_moves = 1;
        tick();
        chk("q_Win", q_Win, 1);
        chk("not_lose_on_win", q_Lose, 0);
        chk("busy_in_win", busy, 0);
        win_flag = 0; no_moves = 0;
        press(4'b1111, 0);
        repeat (2) tick();
        press(4'b0010, 0);
        repeat (3) tick();
        chk("still_win", q_Win, 1);

        // no_moves in IDLE -> LOSE
        apply_reset(2);
        serve_spawn(1, 1'b1, 1);
        no_moves = 1;
        tick();
        no_moves = 0;
        chk("q_Lose_no_moves", q_Lose, 1);
        press(4'b0100, 0);
        repeat (3) tick();
        chk("still_lose", q_Lose, 1);

        // spawn_ok=0 -> LOSE, with a press buffered during SPAWN
        apply_reset(2);
        tick();
        press(4'b0001, 2);
        serve_spawn(1, 1'b0, 1);
        chk("q_Lose_spawn_fail", q_Lose, 1);
        chk("no_idle_after_spawn_fail", q_Idle, 0);
        repeat (4) tick();

        // Reset mid-MOVE, with a press buffered during MOVE
        apply_reset(2);
        serve_spawn(0, 1'b1, 1);
        do_move(4'b0100, 0, 1'b1, 1, 0);
        press(4'b0010, 1);
        wait_req(1'b0);
        press(4'b0001, 2);
        apply_reset(1);
        check_reset_state();
        serve_spawn(1, 1'b1, 1);
        repeat (6) tick();
        chk("idle_after_abort", q_Idle, 1);

        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
